// File: rtl/dist_ram_sdp_clr.sv
// Simple-dual-port distributed RAM with byte enables, registered read and a self-clearing sweep.
// The sweep runs after reset and on clr_req; user ports are ignored while it is active.
module dist_ram_sdp_clr #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DEPTH   = 1 << ADDR_W,
   parameter int unsigned RD_MODE = 0,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_req,
   output logic                  busy,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     din,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_W-1:0]     dout,
   output logic                  dout_valid,
   output logic                  addr_err
);

   localparam int unsigned NB = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);
   localparam bit WR_FIRST = (RD_MODE != 0);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   (* ram_style = "distributed" *) logic [DATA_W-1:0] r_mem [DEPTH];

   state_t              r_state;
   logic [ADDR_W:0]     r_ptr;
   logic                r_busy;
   logic [DATA_W-1:0]   r_dout;
   logic                r_dout_valid;
   logic                r_addr_err;

   logic                w_idle;
   logic                w_wr_in;
   logic                w_rd_in;
   logic                w_wr_bad;
   logic                w_rd_bad;
   logic [DATA_W-1:0]   w_old;
   logic [DATA_W-1:0]   w_merged;
   logic [DATA_W-1:0]   w_rd_word;

   assign w_idle   = (r_state == S_IDLE);
   assign w_wr_in  = w_idle & we & ({1'b0, waddr} < DEPTH_L);
   assign w_rd_in  = w_idle & re & ({1'b0, raddr} < DEPTH_L);
   assign w_wr_bad = w_idle & we & ~({1'b0, waddr} < DEPTH_L);
   assign w_rd_bad = w_idle & re & ~({1'b0, raddr} < DEPTH_L);

   // Read word selection; write-first forwards the byte-merged word on a collision.
   always_comb begin
      w_old     = '0;
      w_merged  = '0;
      w_rd_word = '0;
      if (w_rd_in) begin
         w_old = r_mem[raddr];
      end
      w_merged = w_old;
      for (int i = 0; i < NB; i++) begin
         if (w_wr_in && be[i]) begin
            w_merged[8*i +: 8] = din[8*i +: 8];
         end
      end
      w_rd_word = (WR_FIRST && w_wr_in && (waddr == raddr)) ? w_merged : w_old;
   end

   // Control FSM and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_CLEAR;
         r_ptr        <= '0;
         r_busy       <= 1'b1;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         r_dout_valid <= 1'b0;
         r_addr_err   <= 1'b0;
         case (r_state)
            S_CLEAR: begin
               r_ptr <= r_ptr + (ADDR_W+1)'(1);
               if (r_ptr == LAST_L) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_IDLE: begin
               if (re) begin
                  r_dout       <= w_rd_in ? w_rd_word : '0;
                  r_dout_valid <= 1'b1;
               end
               r_addr_err <= w_wr_bad | w_rd_bad;
               if (clr_req) begin
                  r_state <= S_CLEAR;
                  r_ptr   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_CLEAR;
               r_ptr   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage array: the sweep owns it while clearing, otherwise byte-enabled user writes.
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_mem[r_ptr[ADDR_W-1:0]] <= CLR_VAL;
      end else if (w_wr_in) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               r_mem[waddr][8*i +: 8] <= din[8*i +: 8];
            end
         end
      end
   end

   assign busy       = r_busy;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_dist_ram_sdp_clr.sv
// Bench for dist_ram_sdp_clr: a full-depth read-first instance and a 200-word write-first
// instance share stimulus and are each checked every cycle against an array-based model.
module tb_dist_ram_sdp_clr;

   localparam logic [31:0] CLR_B = 32'h5A5A_0F0F;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr_req = 1'b0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [3:0]  be = '0;
   logic [7:0]  waddr = '0;
   logic [7:0]  raddr = '0;
   logic [31:0] din = '0;

   logic        busy_a, busy_b, dv_a, dv_b, ae_a, ae_b;
   logic [31:0] dout_a, dout_b;

   dist_ram_sdp_clr u_a (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
      .we(we), .be(be), .waddr(waddr), .din(din),
      .re(re), .raddr(raddr), .dout(dout_a), .dout_valid(dv_a), .addr_err(ae_a)
   );

   dist_ram_sdp_clr #(.DEPTH(200), .RD_MODE(1), .CLR_VAL(CLR_B)) u_b (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
      .we(we), .be(be), .waddr(waddr), .din(din),
      .re(re), .raddr(raddr), .dout(dout_b), .dout_valid(dv_b), .addr_err(ae_b)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit checking = 1'b0;

   // Reference model state per instance.
   logic [31:0] m_mem [2][256];
   int          m_ptr [2];
   bit          m_busy [2];
   logic [31:0] e_dout [2];
   bit          e_valid [2];
   bit          e_err [2];

   function automatic int dep(int k);
      return (k == 0) ? 256 : 200;
   endfunction

   function automatic logic [31:0] clrv(int k);
      return (k == 0) ? 32'h0 : CLR_B;
   endfunction

   task automatic step(int k);
      logic [31:0] old, mrg;
      bit rin, win;
      if (m_busy[k]) begin
         m_mem[k][m_ptr[k]] = clrv(k);
         m_ptr[k]++;
         if (m_ptr[k] == dep(k)) m_busy[k] = 1'b0;
         e_valid[k] = 1'b0;
         e_err[k]   = 1'b0;
      end else begin
         win = we && (int'(waddr) < dep(k));
         rin = re && (int'(raddr) < dep(k));
         e_err[k]   = (we && !win) || (re && !rin);
         e_valid[k] = re;
         if (re) begin
            if (rin) begin
               old = m_mem[k][raddr];
               mrg = old;
               if (win && waddr == raddr)
                  for (int i = 0; i < 4; i++) if (be[i]) mrg[8*i +: 8] = din[8*i +: 8];
               e_dout[k] = (k == 1) ? mrg : old;
            end else begin
               e_dout[k] = '0;
            end
         end
         if (win)
            for (int i = 0; i < 4; i++) if (be[i]) m_mem[k][waddr][8*i +: 8] = din[8*i +: 8];
         if (clr_req) begin
            m_busy[k] = 1'b1;
            m_ptr[k]  = 0;
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_busy[k]  = 1'b1;
            m_ptr[k]   = 0;
            e_dout[k]  = '0;
            e_valid[k] = 1'b0;
            e_err[k]   = 1'b0;
         end else begin
            step(k);
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (checking) begin
         chk("a.busy", 32'(busy_a), 32'(m_busy[0]));
         chk("a.dout", dout_a, e_dout[0]);
         chk("a.dout_valid", 32'(dv_a), 32'(e_valid[0]));
         chk("a.addr_err", 32'(ae_a), 32'(e_err[0]));
         chk("b.busy", 32'(busy_b), 32'(m_busy[1]));
         chk("b.dout", dout_b, e_dout[1]);
         chk("b.dout_valid", 32'(dv_b), 32'(e_valid[1]));
         chk("b.addr_err", 32'(ae_b), 32'(e_err[1]));
      end
   end

   task automatic op(bit w, logic [3:0] b, logic [7:0] wa, logic [31:0] d,
                     bit r, logic [7:0] ra, bit c);
      we = w; be = b; waddr = wa; din = d; re = r; raddr = ra; clr_req = c;
      @(posedge clk);
      #1;
      we = 1'b0; re = 1'b0; clr_req = 1'b0;
   endtask

   // Counts cycles with busy high from now until both instances are idle (bounded).
   task automatic count_busy(output int ca, output int cb);
      ca = 0;
      cb = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if (busy_a) ca++;
         if (busy_b) cb++;
         if (!busy_a && !busy_b) break;
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 600; n++) begin
         if (!busy_a && !busy_b) break;
         @(posedge clk);
         #1;
      end
      chk("wait_idle", 32'(busy_a | busy_b), 32'h0);
   endtask

   initial begin
      int ca, cb;
      logic [7:0] wa;
      for (int k = 0; k < 2; k++)
         for (int a = 0; a < 256; a++) m_mem[k][a] = '0;

      #2 rst = 1'b1;
      checking = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      count_busy(ca, cb);
      chk("sweep_len_a", 32'(ca), 32'd256);
      chk("sweep_len_b", 32'(cb), 32'd200);

      // Post-reset contents read back as the clear value.
      op(0, 4'h0, 8'h00, 32'h0, 1, 8'h00, 0);
      chk("t1.a0", dout_a, 32'h0);
      chk("t1.a0v", 32'(dv_a), 32'h1);
      chk("t1.b0", dout_b, CLR_B);
      op(0, 4'h0, 8'h00, 32'h0, 1, 8'h7F, 0);
      chk("t1.a7f", dout_a, 32'h0);
      op(0, 4'h0, 8'h00, 32'h0, 1, 8'hFF, 0);
      chk("t1.aff", dout_a, 32'h0);
      chk("t1.affv", 32'(dv_a), 32'h1);
      chk("t1.bff_err", 32'(ae_b), 32'h1);
      chk("t1.bff", dout_b, 32'h0);

      // Byte-enable merge.
      op(1, 4'hF, 8'h10, 32'hAABBCCDD, 0, 8'h00, 0);
      op(1, 4'b0101, 8'h10, 32'h11223344, 0, 8'h00, 0);
      op(0, 4'h0, 8'h00, 32'h0, 1, 8'h10, 0);
      chk("t2.a", dout_a, 32'hAA22CC44);
      chk("t2.b", dout_b, 32'hAA22CC44);

      // Read/write collision.
      op(1, 4'hF, 8'h20, 32'h1, 0, 8'h00, 0);
      op(1, 4'hF, 8'h20, 32'h2, 1, 8'h20, 0);
      chk("t3.read_first", dout_a, 32'h1);
      chk("t3.write_first", dout_b, 32'h2);

      // Out-of-range access on the 200-word instance.
      op(1, 4'hF, 8'hC8, 32'hDEADBEEF, 0, 8'h00, 0);
      chk("t4.werr_b", 32'(ae_b), 32'h1);
      chk("t4.werr_a", 32'(ae_a), 32'h0);
      op(0, 4'h0, 8'h00, 32'h0, 1, 8'hC8, 0);
      chk("t4.rerr_b", 32'(ae_b), 32'h1);
      chk("t4.rdout_b", dout_b, 32'h0);
      chk("t4.rdv_b", 32'(dv_b), 32'h1);
      chk("t4.rdout_a", dout_a, 32'hDEADBEEF);

      // Randomised traffic with occasional clears.
      for (int n = 0; n < 3000; n++) begin
         wa = 8'($urandom);
         op(1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom),
            ($urandom_range(0, 3) == 0) ? wa : 8'($urandom), ($urandom_range(0, 299) == 0));
      end
      wait_idle();

      // Clear request with user traffic during the sweep.
      for (int n = 0; n < 20; n++) op(1, 4'hF, 8'(n * 9), $urandom, 0, 8'h00, 0);
      op(0, 4'h0, 8'h00, 32'h0, 0, 8'h00, 1);
      for (int n = 0; n < 150; n++)
         op(1'($urandom), 4'($urandom), 8'($urandom), $urandom, 1'($urandom), 8'($urandom), 1'($urandom));
      wait_idle();
      for (int a = 0; a < 256; a++) op(0, 4'h0, 8'h00, 32'h0, 1, 8'(a), 0);
      op(0, 4'h0, 8'h00, 32'h0, 1, 8'h12, 0);
      chk("t5.a", dout_a, 32'h0);
      chk("t5.b", dout_b, CLR_B);

      // Reset during a read.
      op(1, 4'hF, 8'h30, 32'h12345678, 0, 8'h00, 0);
      op(0, 4'h0, 8'h00, 32'h0, 1, 8'h30, 0);
      chk("t6.pre_dout", dout_a, 32'h12345678);
      #2 rst = 1'b1;
      #1;
      chk("t6.rd_busy", 32'(busy_a), 32'h1);
      chk("t6.rd_dv", 32'(dv_a), 32'h0);
      chk("t6.rd_dout", dout_a, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      count_busy(ca, cb);
      chk("t6.len1_a", 32'(ca), 32'd256);
      chk("t6.len1_b", 32'(cb), 32'd200);

      // Reset in the middle of a sweep.
      op(0, 4'h0, 8'h00, 32'h0, 0, 8'h00, 1);
      repeat (100) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("t6.sw_busy", 32'(busy_a), 32'h1);
      chk("t6.sw_dv", 32'(dv_b), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      count_busy(ca, cb);
      chk("t6.len2_a", 32'(ca), 32'd256);
      chk("t6.len2_b", 32'(cb), 32'd200);
      for (int a = 0; a < 256; a += 7) op(0, 4'h0, 8'h00, 32'h0, 1, 8'(a), 0);

      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
